// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - arbitrates the shared 8-digit 7-segment display among NREQ clients
module seg_display_arbiter #(
    parameter int NREQ        = 4,
    parameter int SCAN_DIV    = 5000,
    parameter int BLANK_CYC   = 2,
    parameter int HOLD_FRAMES = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      urgent,
    input  logic [NREQ*64-1:0]   pattern,
    input  logic [NREQ*8-1:0]    digit_en,
    output logic [NREQ-1:0]      grant,
    output logic                 grant_valid,
    output logic [7:0]           AN,
    output logic [7:0]           HEX,
    output logic                 frame_done
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(SCAN_DIV + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   owner, owner_next;
    logic [IW-1:0]   rr_ptr, rr_ptr_next;
    logic [CW-1:0]   count, count_next;
    logic [2:0]      digit, digit_next;
    logic [HW-1:0]   hold, hold_next;
    logic [7:0]      seg_byte, byte_next;
    logic            seg_en, en_next;
    logic [NREQ-1:0] grant_next;
    logic [NREQ-1:0] others, urg_others;
    logic [7:0]      an_next, hex_next;
    logic            fd_next, frame_last;
    logic [IW+5:0]   pat_idx;
    logic [IW+2:0]   en_idx;

    function automatic logic [IW-1:0] lowest(input logic [NREQ-1:0] mask);
        lowest = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (mask[k]) lowest = IW'(k);
        end
    endfunction

    // First set bit strictly after base, wrapping; base itself is checked last.
    function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] base, input logic [NREQ-1:0] mask);
        logic [IW-1:0] idx;
        rr_pick = base;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(base) + k) % NREQ);
            if (mask[idx]) rr_pick = idx;
        end
    endfunction

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            count       <= '0;
            digit       <= '0;
            hold        <= '0;
            seg_byte    <= 8'hFF;
            seg_en      <= 1'b0;
            grant       <= '0;
            grant_valid <= 1'b0;
            AN          <= 8'hFF;
            HEX         <= 8'hFF;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            rr_ptr      <= rr_ptr_next;
            count       <= count_next;
            digit       <= digit_next;
            hold        <= hold_next;
            seg_byte    <= byte_next;
            seg_en      <= en_next;
            grant       <= grant_next;
            grant_valid <= |grant_next;
            AN          <= an_next;
            HEX         <= hex_next;
            frame_done  <= fd_next;
        end
    end

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        count_next  = count;
        digit_next  = digit;
        hold_next   = hold;
        others      = req & ~grant;
        urg_others  = urgent & others;
        frame_last  = (digit == 3'd7) && (count == CW'(SCAN_DIV - 1));
        case (state)
            IDLE: begin
                count_next = '0;
                digit_next = '0;
                hold_next  = '0;
                if (|req) begin
                    state_next  = OWN;
                    owner_next  = (|(urgent & req)) ? lowest(urgent & req) : rr_pick(rr_ptr, req);
                    rr_ptr_next = owner_next;
                end
            end
            default: begin
                if (count == CW'(SCAN_DIV - 1)) begin
                    count_next = '0;
                    digit_next = digit + 3'd1;
                end else begin
                    count_next = count + CW'(1);
                end
                // Counted as the frame_done cycle is entered so the boundary sees this frame.
                if (digit_next == 3'd7 && count_next == CW'(SCAN_DIV - 1) && hold != HW'(HOLD_FRAMES))
                    hold_next = hold + HW'(1);
                if (frame_last) begin
                    if (|urg_others) begin
                        owner_next  = lowest(urg_others);
                        rr_ptr_next = owner_next;
                        hold_next   = '0;
                    end else if (!req[owner] || hold == HW'(HOLD_FRAMES)) begin
                        if (|others) begin
                            owner_next  = rr_pick(owner, others);
                            rr_ptr_next = owner_next;
                            hold_next   = '0;
                        end else if (!req[owner]) begin
                            state_next = IDLE;
                            hold_next  = '0;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        grant_next = '0;
        if (state_next == OWN)
            grant_next = {{(NREQ-1){1'b0}}, 1'b1} << owner_next;
        pat_idx   = {owner_next, digit_next, 3'b000};
        en_idx    = {owner_next, digit_next};
        byte_next = seg_byte;
        en_next   = seg_en;
        if (count_next == '0) begin
            byte_next = pattern[pat_idx +: 8];
            en_next   = digit_en[en_idx];
        end
        an_next  = 8'hFF;
        hex_next = 8'hFF;
        if (state_next == OWN && req[owner_next] && en_next && count_next >= CW'(BLANK_CYC)) begin
            an_next  = ~(8'h01 << digit_next);
            hex_next = byte_next;
        end
        fd_next = (state_next == OWN) && (digit_next == 3'd7) && (count_next == CW'(SCAN_DIV - 1));
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - scoreboard bench for seg_display_arbiter
module tb_seg_display_arbiter;
    localparam int NREQ     = 4;
    localparam int SCAN_DIV = 4;
    localparam int BLANK    = 1;
    localparam int HOLD     = 2;

    logic                clock = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     urgent;
    logic [NREQ*64-1:0]  pattern;
    logic [NREQ*8-1:0]   digit_en;
    logic [NREQ-1:0]     grant;
    logic                grant_valid;
    logic [7:0]          AN;
    logic [7:0]          HEX;
    logic                frame_done;

    typedef struct {
        string      tag;
        logic [3:0] grant;
        logic [7:0] an;
        logic [7:0] hex;
        logic       fd;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pat [NREQ][8];
    logic [7:0] en  [NREQ];
    string      phase;
    int         n_checks = 0;
    int         n_fail   = 0;

    seg_display_arbiter #(
        .NREQ(NREQ), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK), .HOLD_FRAMES(HOLD)
    ) dut (
        .clock(clock), .rst(rst), .req(req), .urgent(urgent), .pattern(pattern),
        .digit_en(digit_en), .grant(grant), .grant_valid(grant_valid), .AN(AN),
        .HEX(HEX), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_images();
        for (int i = 0; i < NREQ; i++) begin
            for (int d = 0; d < 8; d++) pattern[i*64 + d*8 +: 8] = pat[i][d];
            digit_en[i*8 +: 8] = en[i];
        end
    endtask

    // Expected outputs for cycles first..last of a frame owned by o.
    task automatic push_frame(input int o, input int first, input int last, input bit shown);
        exp_t e;
        int   d;
        int   cnt;
        for (int c = first; c <= last; c++) begin
            d       = c / SCAN_DIV;
            cnt     = c % SCAN_DIV;
            e.tag   = $sformatf("%s_o%0d_c%0d", phase, o, c);
            e.grant = 4'(1 << o);
            e.fd    = (c == 8*SCAN_DIV - 1);
            e.an    = 8'hFF;
            e.hex   = 8'hFF;
            if (shown && cnt >= BLANK && en[o][d]) begin
                e.an  = ~(8'h01 << d);
                e.hex = pat[o][d];
            end
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.tag   = $sformatf("%s_idle%0d", phase, k);
            e.grant = '0;
            e.an    = 8'hFF;
            e.hex   = 8'hFF;
            e.fd    = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        check({phase, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({e.tag, "_grant"}, 32'(grant), 32'(e.grant));
        check({e.tag, "_gvalid"}, 32'(grant_valid), 32'(|e.grant));
        check({e.tag, "_an"}, 32'(AN), 32'(e.an));
        check({e.tag, "_hex"}, 32'(HEX), 32'(e.hex));
        check({e.tag, "_fd"}, 32'(frame_done), 32'(e.fd));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            pop_compare();
        end
    endtask

    initial begin
        rst    = 1'b0;
        req    = 4'hF;
        urgent = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int d = 0; d < 8; d++) pat[i][d] = 8'(8'h40 + i*16 + d);
            en[i] = 8'hFF;
        end
        pat[0][0] = 8'hC0;
        apply_images();

        phase = "reset";
        push_idle(3);
        step(3);
        rst = 1'b1;
        req = '0;
        push_idle(3);
        step(3);

        phase = "scan";
        req = 4'b0001;
        push_frame(0, 0, 31, 1);
        push_frame(0, 0, 31, 1);
        step(64);

        // Slot 2 capture happens at its count 0; a later pattern write waits a frame.
        phase = "en";
        en[0] = 8'hFC;
        apply_images();
        push_frame(0, 0, 31, 1);
        step(10);
        pat[0][2] = 8'h12;
        apply_images();
        step(22);
        push_frame(0, 0, 31, 1);
        step(32);
        req   = '0;
        en[0] = 8'hFF;
        apply_images();
        push_idle(2);
        step(2);

        phase = "rr";
        req = 4'b0001;
        push_frame(0, 0, 0, 1);
        step(1);
        req = 4'b0011;
        push_frame(0, 1, 31, 1);
        push_frame(0, 0, 31, 1);
        push_frame(1, 0, 31, 1);
        push_frame(1, 0, 31, 1);
        step(127);

        phase = "urgent";
        push_frame(0, 0, 10, 1);
        step(11);
        req    = 4'b0111;
        urgent = 4'b0101;
        push_frame(0, 11, 31, 1);
        push_frame(2, 0, 0, 1);
        step(22);
        urgent = 4'b0100;
        push_frame(2, 1, 31, 1);
        push_frame(2, 0, 31, 1);
        push_frame(0, 0, 0, 1);
        step(64);

        phase = "drop";
        req    = 4'b0001;
        urgent = '0;
        push_frame(0, 1, 10, 1);
        step(10);
        req = '0;
        push_frame(0, 11, 31, 0);
        push_idle(3);
        step(24);

        phase = "async";
        req = 4'b0010;
        push_frame(1, 0, 6, 1);
        step(7);
        #2 rst = 1'b0;
        #1;
        push_idle(1);
        pop_compare();
        req = '0;
        push_idle(2);
        step(2);
        rst = 1'b1;
        push_idle(2);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
